pid_seq_datapath: RTL and testbench

PID_SEQ_DATAPATH -- requirements
Module: pid_seq_datapath

---
 rtl/pid_seq_datapath.sv | 251 +++++++++++++++++++++++++
 tb/tb_pid_seq_datapath.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pid_seq_datapath.sv
// Sequential PID datapath: error, integrator and derivative terms, three serial
// radix-2 Booth multiplies, then a saturating sum registered onto duty_o.
//
// state | meaning
// IDLE  | waiting for start_i; clr_i clears integrator and previous error
// ERR   | err = sat(xset - xmeas)
// INTEG | sumerr = sat(sumerr + err)
// DIFF  | diferr = sat(err - preverr), preverr = err, load kp*err multiply
// MULP  | W Booth steps of kp*err
// MULI  | W Booth steps of ki*sumerr
// MULD  | W Booth steps of kd*diferr
// SUM1  | acc = sat(P + I)
// SUM2  | acc = sat(acc + D), duty and done registered for the DONE cycle
// DONE  | done_o high for one cycle, back to IDLE
module pid_seq_datapath #(
   parameter int W            = 14,
   parameter int FRAC         = 12,
   parameter int UNSIGNED_OUT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                clr_i,
   input  logic signed [W-1:0] xset_i,
   input  logic signed [W-1:0] xmeas_i,
   input  logic signed [W-1:0] kp_i,
   input  logic signed [W-1:0] ki_i,
   input  logic signed [W-1:0] kd_i,
   output logic signed [W-1:0] duty_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_ERR   = 4'd1;
   localparam logic [3:0] S_INTEG = 4'd2;
   localparam logic [3:0] S_DIFF  = 4'd3;
   localparam logic [3:0] S_MULP  = 4'd4;
   localparam logic [3:0] S_MULI  = 4'd5;
   localparam logic [3:0] S_MULD  = 4'd6;
   localparam logic [3:0] S_SUM1  = 4'd7;
   localparam logic [3:0] S_SUM2  = 4'd8;
   localparam logic [3:0] S_DONE  = 4'd9;

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0]       CNT_LOAD = CW'(W - 1);
   localparam logic signed [W-1:0] MAXV     = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MINV     = {1'b1, {(W-1){1'b0}}};

   function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
      logic signed [W-1:0] s;
      s = a + b;
      if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) return a[W-1] ? MINV : MAXV;
      return s;
   endfunction

   function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
      logic signed [W-1:0] s;
      s = a - b;
      if ((a[W-1] != b[W-1]) && (s[W-1] != a[W-1])) return a[W-1] ? MINV : MAXV;
      return s;
   endfunction

   // Scaled product fits in W bits only if all bits above the W-bit sign agree.
   function automatic logic signed [W-1:0] sat_prod(input logic signed [2*W:0] p);
      logic signed [2*W:0] s;
      s = p >>> FRAC;
      if ((&s[2*W:W-1]) || ~(|s[2*W:W-1])) return s[W-1:0];
      return s[2*W] ? MINV : MAXV;
   endfunction

   logic [3:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic signed [W-1:0] xset_q, xset_d, xmeas_q, xmeas_d;
   logic signed [W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
   logic signed [W-1:0] err_q, err_d, sumerr_q, sumerr_d;
   logic signed [W-1:0] diferr_q, diferr_d, preverr_q, preverr_d;
   logic signed [W-1:0] pterm_q, pterm_d, iterm_q, iterm_d, dterm_q, dterm_d;
   logic signed [W-1:0] acc_q, acc_d, duty_q, duty_d;
   logic signed [2*W:0] prod_q, prod_d;
   logic                booth_q, booth_d;
   logic                busy_q, busy_d, done_q, done_d;

   logic signed [W-1:0]   mcand;
   logic signed [W:0]     hi, hi_sum;
   logic [W-1:0]          lo;
   logic signed [2*W+1:0] shifted;
   logic signed [2*W:0]   prod_step;
   logic                  booth_step;

   // Booth step: hi carries one guard bit so that subtracting the most
   // negative multiplicand cannot overflow.
   always_comb begin
      mcand = kd_q;
      if (state_q == S_MULP) mcand = kp_q;
      else if (state_q == S_MULI) mcand = ki_q;
      hi = prod_q[2*W:W];
      lo = prod_q[W-1:0];
      case ({lo[0], booth_q})
         2'b01:   hi_sum = hi + {mcand[W-1], mcand};
         2'b10:   hi_sum = hi - {mcand[W-1], mcand};
         default: hi_sum = hi;
      endcase
      shifted    = $signed({hi_sum, lo, booth_q}) >>> 1;
      prod_step  = shifted[2*W+1:1];
      booth_step = shifted[0];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      xset_d    = xset_q;
      xmeas_d   = xmeas_q;
      kp_d      = kp_q;
      ki_d      = ki_q;
      kd_d      = kd_q;
      err_d     = err_q;
      sumerr_d  = sumerr_q;
      diferr_d  = diferr_q;
      preverr_d = preverr_q;
      pterm_d   = pterm_q;
      iterm_d   = iterm_q;
      dterm_d   = dterm_q;
      acc_d     = acc_q;
      duty_d    = duty_q;
      prod_d    = prod_q;
      booth_d   = booth_q;
      done_d    = 1'b0;
      busy_d    = (state_q != S_IDLE) && (state_q != S_DONE);
      case (state_q)
         S_IDLE: begin
            if (clr_i) begin
               sumerr_d  = '0;
               preverr_d = '0;
            end
            if (start_i) begin
               xset_d  = xset_i;
               xmeas_d = xmeas_i;
               kp_d    = kp_i;
               ki_d    = ki_i;
               kd_d    = kd_i;
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            err_d   = sat_sub(xset_q, xmeas_q);
            state_d = S_INTEG;
         end
         S_INTEG: begin
            sumerr_d = sat_add(sumerr_q, err_q);
            state_d  = S_DIFF;
         end
         S_DIFF: begin
            diferr_d  = sat_sub(err_q, preverr_q);
            preverr_d = err_q;
            prod_d    = {{(W+1){1'b0}}, err_q};
            booth_d   = 1'b0;
            cnt_d     = CNT_LOAD;
            state_d   = S_MULP;
         end
         S_MULP, S_MULI, S_MULD: begin
            prod_d  = prod_step;
            booth_d = booth_step;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = CNT_LOAD;
               booth_d = 1'b0;
               if (state_q == S_MULP) begin
                  pterm_d = sat_prod(prod_step);
                  prod_d  = {{(W+1){1'b0}}, sumerr_q};
                  state_d = S_MULI;
               end else if (state_q == S_MULI) begin
                  iterm_d = sat_prod(prod_step);
                  prod_d  = {{(W+1){1'b0}}, diferr_q};
                  state_d = S_MULD;
               end else begin
                  dterm_d = sat_prod(prod_step);
                  prod_d  = '0;
                  state_d = S_SUM1;
               end
            end
         end
         S_SUM1: begin
            acc_d   = sat_add(pterm_q, iterm_q);
            state_d = S_SUM2;
         end
         S_SUM2: begin
            // duty is registered here so it appears together with done_o.
            acc_d   = sat_add(acc_q, dterm_q);
            duty_d  = ((UNSIGNED_OUT != 0) && acc_d[W-1]) ? '0 : acc_d;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         xset_q    <= '0;
         xmeas_q   <= '0;
         kp_q      <= '0;
         ki_q      <= '0;
         kd_q      <= '0;
         err_q     <= '0;
         sumerr_q  <= '0;
         diferr_q  <= '0;
         preverr_q <= '0;
         pterm_q   <= '0;
         iterm_q   <= '0;
         dterm_q   <= '0;
         acc_q     <= '0;
         duty_q    <= '0;
         prod_q    <= '0;
         booth_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         xset_q    <= xset_d;
         xmeas_q   <= xmeas_d;
         kp_q      <= kp_d;
         ki_q      <= ki_d;
         kd_q      <= kd_d;
         err_q     <= err_d;
         sumerr_q  <= sumerr_d;
         diferr_q  <= diferr_d;
         preverr_q <= preverr_d;
         pterm_q   <= pterm_d;
         iterm_q   <= iterm_d;
         dterm_q   <= dterm_d;
         acc_q     <= acc_d;
         duty_q    <= duty_d;
         prod_q    <= prod_d;
         booth_q   <= booth_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign duty_o = duty_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_pid_seq_datapath.sv
// Directed bench for pid_seq_datapath: two instances (unsigned and signed duty)
// share one stimulus stream; expected duties are hand-computed per vector.
module tb_pid_seq_datapath;
   localparam int W = 14;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         clr = 1'b0;
   logic [W-1:0] xset = '0, xmeas = '0, kp = '0, ki = '0, kd = '0;
   logic [W-1:0] duty_u, duty_s;
   logic         busy_u, done_u, busy_s, done_s;

   int n_vec = 0;
   int n_err = 0;

   pid_seq_datapath #(.W(W), .FRAC(12), .UNSIGNED_OUT(1)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .start_i(start), .clr_i(clr),
      .xset_i(xset), .xmeas_i(xmeas), .kp_i(kp), .ki_i(ki), .kd_i(kd),
      .duty_o(duty_u), .busy_o(busy_u), .done_o(done_u));

   pid_seq_datapath #(.W(W), .FRAC(12), .UNSIGNED_OUT(0)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .start_i(start), .clr_i(clr),
      .xset_i(xset), .xmeas_i(xmeas), .kp_i(kp), .ki_i(ki), .kd_i(kd),
      .duty_o(duty_s), .busy_o(busy_s), .done_o(done_s));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // One computation; start is sampled at the first posedge. Inputs are
   // scrambled afterwards so any re-sampling shows up in duty.
   task automatic run(input string tag, input int xs, input int xm, input int p,
                      input int i, input int d, input bit do_clr,
                      input int exp_u, input int exp_s, input int pulse_at);
      int lat;
      int bcnt;
      bit got;
      logic [W-1:0] held;
      @(negedge clk);
      xset = xs[W-1:0]; xmeas = xm[W-1:0];
      kp = p[W-1:0]; ki = i[W-1:0]; kd = d[W-1:0];
      start = 1'b1; clr = do_clr;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      xset = ~xset; xmeas = xmeas + 14'd77; kp = ~kp; ki = ~ki; kd = ~kd;
      chk({tag, " busy_first"}, int'(busy_u), 0);
      lat = 0; bcnt = 0; got = 1'b0;
      while (!got && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (busy_u) bcnt++;
         if (done_u) got = 1'b1;
         start = (lat == pulse_at && pulse_at != 0);
      end
      start = 1'b0;
      chk({tag, " latency"}, lat, 47);
      chk({tag, " busy_cycles"}, bcnt, 47);
      chk({tag, " done_s"}, int'(done_s), 1);
      chk({tag, " duty_u"}, int'(duty_u), exp_u);
      chk({tag, " duty_s"}, int'(duty_s), exp_s);
      held = duty_s;
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, int'(done_u), 0);
      chk({tag, " busy_end"}, int'(busy_u), 0);
      chk({tag, " duty_hold"}, int'(duty_s), int'(held));
   endtask

   initial begin
      int ndone;
      #2 rst_n = 1'b0;
      #20;
      chk("rst duty", int'(duty_u), 0);
      chk("rst busy", int'(busy_u), 0);
      chk("rst done", int'(done_u), 0);
      @(negedge clk) rst_n = 1'b1;

      //   tag       xset   xmeas   kp       ki       kd      clr  exp_u   exp_s    pulse
      run("p_path",  100,   40,     'h1000,  0,       0,      0,   60,     60,      0);
      run("i_first", 100,   40,     0,       'h1000,  0,      1,   60,     60,      0);
      run("i_second",100,   40,     0,       'h1000,  0,      0,   120,    120,     0);
      run("clr_start",100,  40,     0,       'h1000,  0,      1,   60,     60,      0);
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      run("d_first", 100,   40,     0,       0,       'h1000, 0,   60,     60,      0);
      run("d_second",100,   40,     0,       0,       'h1000, 0,   0,      0,       0);
      run("sat_pos", 8191,  -8192,  'h1FFF,  0,       0,      0,   8191,   'h1FFF,  0);
      run("sat_neg", 8191,  -8192,  'h2000,  0,       0,      0,   0,      'h2000,  0);
      run("neg_err", 0,     50,     'h1000,  0,       0,      0,   0,      'h3FCE,  0);
      run("floor",   0,     21,     'h0800,  0,       0,      1,   0,      'h3FF5,  0);
      run("pid_a",   30,    10,     'h0800,  'h0400,  'h1000, 1,   35,     35,      0);
      run("pid_b",   30,    10,     'h0800,  'h0400,  'h1000, 0,   20,     20,      0);
      run("collide", 100,   40,     'h1000,  0,       0,      0,   60,     60,      10);
      ndone = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done_u) ndone++;
      end
      chk("collide extra_done", ndone, 0);
      run("d_neg",   0,     0,      0,       0,       'h1000, 0,   0,      'h3FC4,  0);

      // Abort a computation with reset at its 20th cycle.
      @(negedge clk);
      xset = 14'd100; xmeas = 14'd40; kp = '0; ki = 14'h1000; kd = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort busy_before", int'(busy_u), 1);
      rst_n = 1'b0;
      #1;
      chk("abort busy", int'(busy_u), 0);
      chk("abort duty_s", int'(duty_s), 0);
      chk("abort done", int'(done_u), 0);
      @(negedge clk) rst_n = 1'b1;
      ndone = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done_u) ndone++;
      end
      chk("abort no_done", ndone, 0);
      chk("abort duty_u", int'(duty_u), 0);
      run("post_rst", 100,  40,     0,       'h1000,  0,      0,   60,     60,      0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
